// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the DE/EX stage register.
// Tracks destinations of instructions in EX and MEM, detects RAW / load-use
// hazards against DE, and drives PC/IF-DE stall, DE/EX bubble and branch flush.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | previous cycle issued normally
// STALL | previous cycle held PC and IF/DE and inserted a DE/EX bubble
// FLUSH | previous cycle squashed IF/DE for a taken branch
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic              de_rs1_used,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_ru_write,
  input  logic              de_is_load,
  input  logic              ex_br_taken,
  output logic              pc_stall,
  output logic              fd_stall,
  output logic              fd_flush,
  output logic              de_ex_bubble,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  // EX and MEM scoreboard slots. The register file is write-before-read, so an
  // instruction in WB can never cause a hazard; it simply retires out of MEM.
  // The MEM slot does not keep the load flag: loads only matter while in EX.
  logic              ex_v, ex_wr, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_wr;
  logic [REG_AW-1:0] mem_rd;

  logic match_ex, match_mem, hazard;

  // Source/destination compare against EX and MEM; x0 never matches.
  always_comb begin
    match_ex  = ex_v & ex_wr & (ex_rd != '0) &
                ((de_rs1_used & (de_rs1 == ex_rd)) | (de_rs2_used & (de_rs2 == ex_rd)));
    match_mem = mem_v & mem_wr & (mem_rd != '0) &
                ((de_rs1_used & (de_rs1 == mem_rd)) | (de_rs2_used & (de_rs2 == mem_rd)));
    if (FWD_EN) hazard = de_valid & match_ex & ex_ld;
    else        hazard = de_valid & (match_ex | match_mem);
  end

  // Next-state and zero-latency control outputs; a taken branch wins over a hazard.
  always_comb begin
    state_d      = RUN;
    pc_stall     = 1'b0;
    fd_stall     = 1'b0;
    fd_flush     = 1'b0;
    de_ex_bubble = 1'b0;
    if (ex_br_taken) begin
      state_d      = FLUSH;
      fd_flush     = 1'b1;
      de_ex_bubble = 1'b1;
    end else if (hazard) begin
      state_d      = STALL;
      pc_stall     = 1'b1;
      fd_stall     = 1'b1;
      de_ex_bubble = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign hz_state = state_q;

  // Scoreboard shift: DE enters EX unless bubbled or empty, EX moves to MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_wr <= 1'b0;
      mem_rd <= '0;
    end else begin
      ex_v   <= de_valid & ~de_ex_bubble;
      ex_wr  <= de_ru_write;
      ex_ld  <= de_is_load;
      ex_rd  <= de_rd;
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
    end
  end

  // Saturating performance counters: stall cycles and flush events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (fd_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with forwarding, one without,
// both driven from the same DE/branch stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de_valid = 1'b0;
  logic [4:0] de_rs1 = '0;
  logic       de_rs1_used = 1'b0;
  logic [4:0] de_rs2 = '0;
  logic       de_rs2_used = 1'b0;
  logic [4:0] de_rd = '0;
  logic       de_ru_write = 1'b0;
  logic       de_is_load = 1'b0;
  logic       ex_br_taken = 1'b0;

  logic        f_pc_stall, f_fd_stall, f_fd_flush, f_bubble;
  logic [1:0]  f_hz;
  logic [15:0] f_stall_cnt, f_flush_cnt;
  logic        n_pc_stall, n_fd_stall, n_fd_flush, n_bubble;
  logic [1:0]  n_hz;
  logic [15:0] n_stall_cnt, n_flush_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_f (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
    .de_rs2(de_rs2), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_ru_write(de_ru_write), .de_is_load(de_is_load),
    .ex_br_taken(ex_br_taken),
    .pc_stall(f_pc_stall), .fd_stall(f_fd_stall), .fd_flush(f_fd_flush),
    .de_ex_bubble(f_bubble), .hz_state(f_hz),
    .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt)
  );

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u_n (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
    .de_rs2(de_rs2), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_ru_write(de_ru_write), .de_is_load(de_is_load),
    .ex_br_taken(ex_br_taken),
    .pc_stall(n_pc_stall), .fd_stall(n_fd_stall), .fd_flush(n_fd_flush),
    .de_ex_bubble(n_bubble), .hz_state(n_hz),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply a DE instruction / branch input, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic rs1u,
                       input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
    de_valid = v; de_rs1 = rs1; de_rs1_used = rs1u; de_rs2 = rs2; de_rs2_used = rs2u;
    de_rd = rd; de_ru_write = wr; de_is_load = ld; ex_br_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #5;
    chk("rst_pc_stall", f_pc_stall, 1'b0);
    chk("rst_bubble", f_bubble, 1'b0);
    chk("rst_hz", f_hz, 2'd0);
    chk("rst_stall_cnt", f_stall_cnt, 16'd0);
    chk("rst_flush_cnt", n_flush_cnt, 16'd0);
    do_reset();

    // 1: load-use, lw x5 then add x6,x5,x1
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("t1_lw_no_stall", f_pc_stall, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("t1_f_pc_stall", f_pc_stall, 1'b1);
    chk("t1_f_fd_stall", f_fd_stall, 1'b1);
    chk("t1_f_bubble", f_bubble, 1'b1);
    chk("t1_f_flush", f_fd_flush, 1'b0);
    chk("t1_n_pc_stall", n_pc_stall, 1'b1);
    tick();
    chk("t1_f_released", f_pc_stall, 1'b0);
    chk("t1_f_hz_stall", f_hz, 2'd1);
    chk("t1_f_stall_cnt", f_stall_cnt, 16'd1);
    chk("t1_n_stall2", n_pc_stall, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_f_hz_run", f_hz, 2'd0);
    chk("t1_f_stall_cnt_hold", f_stall_cnt, 16'd1);
    chk("t1_n_stall_cnt", n_stall_cnt, 16'd2);
    chk("t1_n_hz", n_hz, 2'd1);

    // 2: ALU producer, forwarding vs none
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("t2_f_no_stall", f_pc_stall, 1'b0);
    chk("t2_n_stall_ex", n_pc_stall, 1'b1);
    tick();
    chk("t2_f_no_stall2", f_pc_stall, 1'b0);
    chk("t2_n_stall_mem", n_pc_stall, 1'b1);
    tick();
    chk("t2_n_released", n_pc_stall, 1'b0);
    chk("t2_n_stall_cnt", n_stall_cnt, 16'd2);
    chk("t2_f_stall_cnt", f_stall_cnt, 16'd0);

    // 3: x0 and unused rs2 never hazard
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("t3_f_x0", f_pc_stall, 1'b0);
    chk("t3_n_x0", n_pc_stall, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("t3_f_rs2_unused", f_pc_stall, 1'b0);
    chk("t3_n_rs2_unused", n_pc_stall, 1'b0);

    // 4: taken branch overrides load-use hazard
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    chk("t4_flush", f_fd_flush, 1'b1);
    chk("t4_bubble", f_bubble, 1'b1);
    chk("t4_pc_stall", f_pc_stall, 1'b0);
    chk("t4_fd_stall", f_fd_stall, 1'b0);
    chk("t4_n_flush", n_fd_flush, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t4_hz_flush", f_hz, 2'd2);
    chk("t4_flush_cnt", f_flush_cnt, 16'd1);
    chk("t4_stall_cnt", f_stall_cnt, 16'd0);

    // 5: back-to-back taken branches
    do_reset();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_hz_1", f_hz, 2'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_hz_2", f_hz, 2'd2);
    chk("t5_flush_cnt", f_flush_cnt, 16'd2);
    tick();
    chk("t5_hz_run", f_hz, 2'd0);
    chk("t5_flush_cnt_hold", f_flush_cnt, 16'd2);

    // 6: asynchronous reset in the middle of a stall
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("t6_n_stall", n_pc_stall, 1'b1);
    tick();
    chk("t6_n_stall2", n_pc_stall, 1'b1);
    chk("t6_n_cnt", n_stall_cnt, 16'd1);
    chk("t6_n_hz", n_hz, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pc_stall", n_pc_stall, 1'b0);
    chk("t6_rst_bubble", n_bubble, 1'b0);
    chk("t6_rst_cnt", n_stall_cnt, 16'd0);
    chk("t6_rst_hz", n_hz, 2'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_after_n", n_pc_stall, 1'b0);
    chk("t6_after_f", f_pc_stall, 1'b0);
    tick();
    chk("t6_after_hz", n_hz, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
